// File: rtl/store_serializer_if.sv
// Job, vector-input and write-port signals of store_serializer.
// slave is the serializer's view; master is the controller/upstream/memory side.
interface store_serializer_if #(
  parameter int unsigned MAC_NUM = 112,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OUT_W   = 64,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CNT_W   = 10
);

  logic                      job_start;
  logic [ADDR_W-1:0]         job_base;
  logic [CNT_W-1:0]          job_num;
  logic                      vec_vld;
  logic [MAC_NUM*DATA_W-1:0] vec_data;
  logic                      vec_rdy;
  logic                      wr_vld;
  logic [ADDR_W-1:0]         wr_addr;
  logic [OUT_W-1:0]          wr_data;
  logic                      wr_rdy;
  logic                      busy;
  logic                      job_done;

  modport master (
    output job_start, job_base, job_num, vec_vld, vec_data, wr_rdy,
    input  vec_rdy, wr_vld, wr_addr, wr_data, busy, job_done
  );

  modport slave (
    input  job_start, job_base, job_num, vec_vld, vec_data, wr_rdy,
    output vec_rdy, wr_vld, wr_addr, wr_data, busy, job_done
  );

endinterface

// File: rtl/store_serializer.sv
// Captures MAC_NUM-lane result vectors and writes them as OUT_W-bit beats to feature-map memory.
// Optional build macro RELU_EN: negative lanes are zeroed at capture.
module store_serializer #(
  parameter int unsigned MAC_NUM = 112,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OUT_W   = 64,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CNT_W   = 10
) (
  input logic               clk,
  input logic               rst,
  store_serializer_if.slave bus
);

  localparam int unsigned LPB    = OUT_W / DATA_W;
  localparam int unsigned BEATS  = MAC_NUM / LPB;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]                     state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [CNT_W-1:0]               left_q, left_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [MAC_NUM-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [MAC_NUM-1:0][DATA_W-1:0] lanes_in, lanes_cap;
  logic [BEATS-1:0][OUT_W-1:0]    shadow_beats;

  assign lanes_in     = bus.vec_data;
  assign shadow_beats = shadow_q;

  always_comb begin
    lanes_cap = lanes_in;
`ifdef RELU_EN
    for (int j = 0; j < int'(MAC_NUM); j++) begin
      if (lanes_in[j][DATA_W-1]) lanes_cap[j] = '0;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    case (state_q)
      StIdle: begin
        if (bus.job_start) begin
          addr_d  = bus.job_base;
          left_d  = bus.job_num;
          state_d = (bus.job_num == '0) ? StDone : StWait;
        end
      end
      StWait: begin
        if (bus.vec_vld) begin
          shadow_d = lanes_cap;
          beat_d   = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (bus.wr_rdy) begin
          // Address wraps modulo 2^ADDR_W by plain overflow.
          addr_d = addr_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            left_d  = left_q - 1'b1;
            state_d = (left_q == CNT_W'(1)) ? StDone : StWait;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      left_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      beat_q  <= beat_d;
    end
  end

  // Shadow contents are only observed in SEND, so no reset is needed.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign bus.vec_rdy  = (state_q == StWait);
  assign bus.wr_vld   = (state_q == StSend);
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = (state_q == StSend) ? shadow_beats[beat_q] : '0;
  assign bus.busy     = (state_q != StIdle);
  assign bus.job_done = (state_q == StDone);

endmodule
